// File: rtl/speed_tick_gen_if.sv
// speed_tick_gen_if: control and status bundle between a game controller and speed_tick_gen.
interface speed_tick_gen_if #(
   parameter int NUM_RATES = 4,
   parameter int TCNT_W = 16
);
   localparam int RS_W = $clog2(NUM_RATES);
   logic run;
   logic restart;
   logic [RS_W-1:0] rate_sel;
   logic ramp_mode;
   logic tick;
   logic [RS_W-1:0] active_rate;
   logic [TCNT_W-1:0] tick_count;
   modport master(output run, restart, rate_sel, ramp_mode, input tick, active_rate, tick_count);
   modport slave(input run, restart, rate_sel, ramp_mode, output tick, active_rate, tick_count);
endinterface

// File: rtl/speed_tick_gen.sv
// speed_tick_gen: selectable-rate tick enable generator with optional speed ramp (macro SPEED_RAMP_EN).
module speed_tick_gen #(
   parameter int NUM_RATES = 4,
   parameter int CNT_W = 20,
   parameter logic [CNT_W-1:0] DIV_TABLE [NUM_RATES] = '{CNT_W'(415000), CNT_W'(370000), CNT_W'(310000), CNT_W'(250000)},
   parameter int RAMP_TICKS = 64,
   parameter int TCNT_W = 16
) (
   input logic clk,
   input logic reset,
   speed_tick_gen_if.slave bus
);
   localparam int RS_W = $clog2(NUM_RATES);
   localparam logic [RS_W:0] TOP = (RS_W+1)'(NUM_RATES - 1);
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] div_a;
   logic [RS_W-1:0] sel_c;
   logic [RS_W-1:0] lvl_nxt;
   logic [RS_W-1:0] target;
   logic [RS_W:0] sum;
   logic wrap;
   always_comb begin
      sel_c = ({1'b0, bus.rate_sel} > TOP) ? TOP[RS_W-1:0] : bus.rate_sel;
      div_a = (DIV_TABLE[bus.active_rate] < CNT_W'(2)) ? CNT_W'(2) : DIV_TABLE[bus.active_rate];
      wrap = bus.run && (cnt == div_a - CNT_W'(1));
      sum = {1'b0, sel_c} + {1'b0, lvl_nxt};
      target = (sum > TOP) ? TOP[RS_W-1:0] : sum[RS_W-1:0];
   end
`ifdef SPEED_RAMP_EN
   localparam int RC_W = $clog2(RAMP_TICKS + 1);
   logic [RC_W-1:0] ramp_cnt;
   logic [RS_W-1:0] ramp_level;
   logic step;
   // the level bumped by this tick already governs the period that starts now
   always_comb begin
      step = wrap && bus.ramp_mode && (ramp_cnt == RC_W'(RAMP_TICKS - 1));
      lvl_nxt = (step && ({1'b0, ramp_level} < TOP)) ? ramp_level + RS_W'(1) : ramp_level;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         ramp_cnt <= '0;
         ramp_level <= '0;
      end else if (bus.restart) begin
         ramp_cnt <= '0;
         ramp_level <= '0;
      end else if (wrap && bus.ramp_mode) begin
         ramp_cnt <= step ? '0 : ramp_cnt + RC_W'(1);
         ramp_level <= lvl_nxt;
      end
`else
   assign lvl_nxt = '0;
`endif
   // rate changes land only between periods so no period is cut short or stretched
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt <= '0;
         bus.tick <= 1'b0;
         bus.tick_count <= '0;
         bus.active_rate <= '0;
      end else if (bus.restart) begin
         cnt <= '0;
         bus.tick <= 1'b0;
         bus.tick_count <= '0;
         bus.active_rate <= sel_c;
      end else begin
         bus.tick <= wrap;
         if (wrap) begin
            cnt <= '0;
            bus.tick_count <= bus.tick_count + TCNT_W'(1);
         end else if (bus.run) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (wrap || !bus.run)
            bus.active_rate <= target;
      end
endmodule

// File: doc/speed_tick_gen.md
SPEED_TICK_GEN -- requirements
Module: speed_tick_gen

Interface
REQ-001 SHALL have parameter NUM_RATES, default 4: number of selectable tick rates, range 2..16.
REQ-002 SHALL have parameter CNT_W, default 20: width of the divisor and period counter.
REQ-003 SHALL have parameter DIV_TABLE, an array of NUM_RATES entries, each CNT_W bits, default {415000, 370000, 310000, 250000}: entry i is the period of rate i in clk cycles.
REQ-004 SHALL have parameter RAMP_TICKS, default 64: number of ticks per ramp step.
REQ-005 SHALL have parameter TCNT_W, default 16: width of tick_count.
REQ-006 SHALL have port clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port run, input, 1 bit: counting enable.
REQ-009 SHALL have port restart, input, 1 bit: synchronous clear, e.g. on goal or start_game.
REQ-010 SHALL have port rate_sel, input, RS_W = $clog2(NUM_RATES) bits: requested base rate.
REQ-011 SHALL have port ramp_mode, input, 1 bit: enables automatic speed-up.
REQ-012 SHALL have port tick, output, 1 bit: single-cycle enable pulse.
REQ-013 SHALL have port active_rate, output, RS_W bits: index of the rate currently in effect.
REQ-014 SHALL have port tick_count, output, TCNT_W bits: wrapping count of ticks.

Function
REQ-015 SHALL generate only clk-domain enable pulses, never derived or muxed clocks.
REQ-016 SHALL clamp any DIV_TABLE entry below 2 to 2; any rate_sel value >= NUM_RATES SHALL select NUM_RATES-1.
REQ-017 SHALL, on each edge with run=1 and restart=0, increment cnt, or set cnt to 0 when cnt = DIV(active_rate)-1.
REQ-018 SHALL register tick=1 at the wrap edge and 0 at every other edge, giving exactly one tick per DIV cycles of run=1.
REQ-019 SHALL hold cnt, with tick=0, on every edge where run=0.
REQ-020 SHALL load active_rate from target = min(clamp(rate_sel) + ramp_level, NUM_RATES-1) only at a wrap edge or on an edge with run=0, so no period is ever truncated or stretched mid-count.
REQ-021 SHALL, when restart=1 (priority over run), clear cnt, tick, ramp_cnt, ramp_level and tick_count, and load active_rate = clamp(rate_sel).
REQ-022 SHALL, on each tick edge with ramp_mode=1, increment ramp_cnt; at ramp_cnt = RAMP_TICKS-1 it SHALL zero ramp_cnt and increment ramp_level, saturating at NUM_RATES-1.
REQ-023 SHALL, when ramp_mode=0, hold ramp_cnt and ramp_level; ramp_level is cleared only by restart or reset.
REQ-024 SHALL increment tick_count at each tick edge, wrapping modulo 2^TCNT_W.
REQ-025 SHALL, on a wrap edge where rate_sel changes at the same time, issue the tick for the old period and apply the new rate from the next count.

Reset
REQ-026 SHALL, while reset=1, asynchronously force cnt=0, tick=0, ramp_cnt=0, ramp_level=0, tick_count=0 and active_rate=0.
REQ-027 SHALL sample rate_sel into active_rate at the first edge after reset release, through the run=0 or wrap path.

Configuration
REQ-028 SHALL compile in ramp_cnt, ramp_level and the REQ-022 behaviour when macro SPEED_RAMP_EN is defined.
REQ-029 SHALL, when SPEED_RAMP_EN is undefined, treat ramp_level as constant 0, ignore ramp_mode, contain no ramp registers, and leave the port list unchanged.

Verification
Bench parameters: NUM_RATES=4, DIV_TABLE={8,6,4,1}, RAMP_TICKS=3.
REQ-030 SHALL cover: rate_sel=0, run=1 for 40 cycles -> 5 ticks, 8 cycles apart, each 1 cycle wide; tick_count=5.
REQ-031 SHALL cover: rate_sel=3 -> period 2 (divisor clamped from 1); rate_sel switched 0->2 at cnt=3 -> the current 8-cycle period completes, then 4-cycle periods follow.
REQ-032 SHALL cover: run dropped for 10 cycles at cnt=5 -> no ticks; after run returns, the next tick comes 3 cycles later.
REQ-033 SHALL cover: SPEED_RAMP_EN defined, ramp_mode=1, rate_sel=0 -> active_rate steps 0->1->2->3 after ticks 3, 6 and 9, then saturates at 3; without the macro, active_rate stays 0.
REQ-034 SHALL cover: restart asserted on the same edge as a wrap -> no tick, tick_count=0, cnt=0, active_rate=rate_sel.
REQ-035 SHALL cover: reset asserted mid-count between edges -> tick and all counters are 0 immediately, before the next edge.
